alu_wb_buffer: RTL and testbench

- Result buffer directly downstream of the ALU unit.
- Captures every completed ALU result (done/id/rd) into a small in-order FIFO and presents it to the writeback arbiter with a valid/ack handshake.
- Supplies the ALU's issue-ready so the issue stage stalls ALU ops when the arbiter backs up.
- Includes a flush path and a sticky overflow flag for protocol checking.

---
 rtl/alu_wb_buffer_pkg.sv | 18 +
 rtl/alu_wb_buffer_if.sv | 25 ++
 rtl/alu_wb_buffer_fifo_mem.sv | 22 ++
 rtl/alu_wb_buffer.sv | 88 ++++++++
 tb/tb_alu_wb_buffer.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/alu_wb_buffer_pkg.sv
// Shared core configuration and type definitions used by the ALU writeback buffer.
// XLEN comes from the core configuration; the id and entry types are shared across units.
package taiga_config;
  localparam int XLEN = 32;
endpackage

package taiga_types;
  import taiga_config::*;

  localparam int ID_W = 3;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    id_t             id;
    logic [XLEN-1:0] rd;
  } alu_wb_entry_t;
endpackage

// File: rtl/alu_wb_buffer_if.sv
// Handshake bundle between the ALU, the result buffer and the writeback arbiter.
// The master modport is the environment (ALU + arbiter); the slave modport is the buffer.
interface alu_wb_if #(
  parameter int XLEN = 32,
  parameter int ID_W = 3
);
  logic            alu_done;
  logic [ID_W-1:0] alu_id;
  logic [XLEN-1:0] alu_rd;
  logic            unit_ready;
  logic            wb_valid;
  logic [ID_W-1:0] wb_id;
  logic [XLEN-1:0] wb_rd;
  logic            wb_ack;

  modport master (
    output alu_done, alu_id, alu_rd, wb_ack,
    input  unit_ready, wb_valid, wb_id, wb_rd
  );

  modport slave (
    input  alu_done, alu_id, alu_rd, wb_ack,
    output unit_ready, wb_valid, wb_id, wb_rd
  );
endinterface

// File: rtl/alu_wb_buffer_fifo_mem.sv
// Result storage: DEPTH entries, one synchronous write port and one asynchronous read port.
module alu_wb_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by count, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/alu_wb_buffer.sv
// In-order result buffer between the ALU and the writeback arbiter, with flush and a sticky
// overflow flag. Head outputs come straight from storage; a small hold register covers the empty case.
module alu_wb_buffer
  import taiga_types::*;
#(
  parameter int XLEN  = taiga_config::XLEN,
  parameter int ID_W  = taiga_types::ID_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  alu_wb_if.slave                wb,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  alu_wb_entry_t wr_entry;
  alu_wb_entry_t rd_entry;
  alu_wb_entry_t hold_q;

  // Full is judged on occupancy, never on pointer equality.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = wb.alu_done && !full;
  assign pop   = wb.wb_ack && !empty;

  assign wr_entry.id = wb.alu_id;
  assign wr_entry.rd = wb.alu_rd;

  alu_wb_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(alu_wb_entry_t))
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // NOTE: all state is updated with non-blocking assignments under an asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      hold_q       <= '0;
      overflow_err <= 1'b0;
    end else begin
      // Any attempted push into a full buffer is a protocol error, independent of pop or flush.
      if (wb.alu_done && full) overflow_err <= 1'b1;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        if (!empty) hold_q <= rd_entry;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
          hold_q <= rd_entry;
        end
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign wb.unit_ready = !full;
  assign wb.wb_valid   = !empty;
  assign wb.wb_id      = empty ? hold_q.id : rd_entry.id;
  assign wb.wb_rd      = empty ? hold_q.rd : rd_entry.rd;
endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed, table-driven bench for alu_wb_buffer: each row drives one cycle of inputs and
// checks the outputs that should be visible during that cycle, before the edge that applies them.
module tb_alu_wb_buffer;
  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       overflow_err;

  int total_checks;
  int passed_checks;

  alu_wb_if #(.XLEN(32), .ID_W(3)) bus ();

  alu_wb_buffer #(.XLEN(32), .ID_W(3), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wb           (bus.slave),
    .count        (count),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic [2:0]  id;
    logic [31:0] rd;
    logic        ack;
    logic        fl;
    logic        exp_valid;
    logic [2:0]  exp_id;
    logic [31:0] exp_rd;
    logic [2:0]  exp_count;
    logic        exp_ready;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic done, logic [2:0] id, logic [31:0] rd, logic ack, logic fl,
                              logic ev, logic [2:0] eid, logic [31:0] erd, logic [2:0] ecnt,
                              logic erdy, logic eovf);
    vec_t v;
    v.done = done; v.id = id; v.rd = rd; v.ack = ack; v.fl = fl;
    v.exp_valid = ev; v.exp_id = eid; v.exp_rd = erd; v.exp_count = ecnt;
    v.exp_ready = erdy; v.exp_ovf = eovf;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic check_outputs(input int idx, input logic ev, input logic [2:0] eid,
                               input logic [31:0] erd, input logic [2:0] ecnt,
                               input logic erdy, input logic eovf);
    check("wb_valid", idx, 32'(bus.wb_valid), 32'(ev));
    check("wb_id", idx, 32'(bus.wb_id), 32'(eid));
    check("wb_rd", idx, bus.wb_rd, erd);
    check("count", idx, 32'(count), 32'(ecnt));
    check("unit_ready", idx, 32'(bus.unit_ready), 32'(erdy));
    check("overflow_err", idx, 32'(overflow_err), 32'(eovf));
  endtask

  task automatic drive(input logic done, input logic [2:0] id, input logic [31:0] rd,
                       input logic ack, input logic fl);
    bus.alu_done = done;
    bus.alu_id   = id;
    bus.alu_rd   = rd;
    bus.wb_ack   = ack;
    flush        = fl;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);

    // Basic latency: push in N, visible in N+1 only, count back to 0 in N+2.
    vecs.push_back(mk(1, 3'd1, 32'h0000_00AA, 1, 0,  0, 3'd0, 32'h0,   3'd0, 1, 0));
    vecs.push_back(mk(0, 3'd0, 32'h0,         1, 0,  1, 3'd1, 32'hAA,  3'd1, 1, 0));
    vecs.push_back(mk(0, 3'd0, 32'h0,         0, 0,  0, 3'd1, 32'hAA,  3'd0, 1, 0));
    // Fill and backpressure.
    vecs.push_back(mk(1, 3'd0, 32'h10, 0, 0,  0, 3'd1, 32'hAA, 3'd0, 1, 0));
    vecs.push_back(mk(1, 3'd1, 32'h11, 0, 0,  1, 3'd0, 32'h10, 3'd1, 1, 0));
    vecs.push_back(mk(1, 3'd2, 32'h12, 0, 0,  1, 3'd0, 32'h10, 3'd2, 1, 0));
    vecs.push_back(mk(1, 3'd3, 32'h13, 0, 0,  1, 3'd0, 32'h10, 3'd3, 1, 0));
    vecs.push_back(mk(0, 3'd0, 32'h0,  0, 0,  1, 3'd0, 32'h10, 3'd4, 0, 0));
    vecs.push_back(mk(0, 3'd0, 32'h0,  1, 0,  1, 3'd0, 32'h10, 3'd4, 0, 0));
    vecs.push_back(mk(0, 3'd0, 32'h0,  0, 0,  1, 3'd1, 32'h11, 3'd3, 1, 0));
    vecs.push_back(mk(1, 3'd4, 32'h14, 0, 0,  1, 3'd1, 32'h11, 3'd3, 1, 0));
    // Overflow: push while full with a simultaneous pop is dropped.
    vecs.push_back(mk(1, 3'd5, 32'hDEAD, 1, 0,  1, 3'd1, 32'h11, 3'd4, 0, 0));
    vecs.push_back(mk(0, 3'd0, 32'h0,    1, 0,  1, 3'd2, 32'h12, 3'd3, 1, 1));
    vecs.push_back(mk(0, 3'd0, 32'h0,    1, 0,  1, 3'd3, 32'h13, 3'd2, 1, 1));
    vecs.push_back(mk(0, 3'd0, 32'h0,    0, 0,  1, 3'd4, 32'h14, 3'd1, 1, 1));
    vecs.push_back(mk(0, 3'd0, 32'h0,    0, 1,  1, 3'd4, 32'h14, 3'd1, 1, 1));
    vecs.push_back(mk(0, 3'd0, 32'h0,    0, 0,  0, 3'd4, 32'h14, 3'd0, 1, 1));
    // Simultaneous push/pop for 10 cycles across the pointer wrap.
    vecs.push_back(mk(1, 3'd0, 32'h100, 1, 0,  0, 3'd4, 32'h14, 3'd0, 1, 1));
    for (int i = 1; i < 10; i++)
      vecs.push_back(mk(1, 3'(i), 32'h100 + 32'(i), 1, 0,
                        1, 3'(i - 1), 32'h100 + 32'(i - 1), 3'd1, 1, 1));
    vecs.push_back(mk(0, 3'd0, 32'h0, 1, 0,  1, 3'd1, 32'h109, 3'd1, 1, 1));
    vecs.push_back(mk(0, 3'd0, 32'h0, 0, 0,  0, 3'd1, 32'h109, 3'd0, 1, 1));
    // Flush priority over a same-cycle push and pop.
    vecs.push_back(mk(1, 3'd0, 32'h200, 0, 0,  0, 3'd1, 32'h109, 3'd0, 1, 1));
    vecs.push_back(mk(1, 3'd1, 32'h201, 0, 0,  1, 3'd0, 32'h200, 3'd1, 1, 1));
    vecs.push_back(mk(1, 3'd2, 32'h202, 0, 0,  1, 3'd0, 32'h200, 3'd2, 1, 1));
    vecs.push_back(mk(1, 3'd7, 32'h777, 1, 1,  1, 3'd0, 32'h200, 3'd3, 1, 1));
    vecs.push_back(mk(0, 3'd0, 32'h0,   0, 0,  0, 3'd0, 32'h200, 3'd0, 1, 1));
    vecs.push_back(mk(1, 3'd6, 32'h300, 0, 0,  0, 3'd0, 32'h200, 3'd0, 1, 1));
    vecs.push_back(mk(0, 3'd0, 32'h0,   1, 0,  1, 3'd6, 32'h300, 3'd1, 1, 1));
    vecs.push_back(mk(0, 3'd0, 32'h0,   0, 0,  0, 3'd6, 32'h300, 3'd0, 1, 1));

    // Reset state.
    repeat (2) @(negedge clk);
    #1 check_outputs(-1, 1'b0, 3'd0, 32'h0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].done, vecs[i].id, vecs[i].rd, vecs[i].ack, vecs[i].fl);
      #1 check_outputs(i, vecs[i].exp_valid, vecs[i].exp_id, vecs[i].exp_rd,
                       vecs[i].exp_count, vecs[i].exp_ready, vecs[i].exp_ovf);
      @(negedge clk);
    end

    // Asynchronous reset mid-traffic: push two entries, then drop rst between edges.
    drive(1'b1, 3'd2, 32'h500, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'd3, 32'h501, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    #1 check("count_before_reset", 100, 32'(count), 32'd2);
    #1 rst = 1'b0;
    #1 check_outputs(101, 1'b0, 3'd0, 32'h0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1 check_outputs(102, 1'b0, 3'd0, 32'h0, 3'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end
endmodule
